channel_mixer_pwm: RTL and testbench

Parametrised N-channel audio mixer and PWM output stage for the synth datapath, sitting between the channel generators (pulse, triangle, …) and the PMOD audio pins. On each sample strobe it snapshots all channel samples and applies per-channel mute and shift attenuation. It then accumulates the channels sequentially, one per clock, saturates the sum and hands it to an internal free-running PWM. The PWM reloads its compare value only at period wrap, so the output stays glitch-free.

---
 rtl/channel_mixer_pwm_if.sv | 31 +++
 rtl/channel_mixer_pwm.sv | 163 ++++++++++++++++
 tb/tb_channel_mixer_pwm.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/channel_mixer_pwm_if.sv
// Interface bundle for channel_mixer_pwm: channel sample inputs, mix
// request/result signals and the PWM pin outputs.
// The master side drives samples and strobes; the slave side is the mixer.
interface channel_mixer_pwm_if #(
    parameter int NUM_CHANNELS = 4,
    parameter int SAMPLE_WIDTH = 9,
    parameter int ATTEN_WIDTH  = 2,
    parameter int PWM_WIDTH    = 10
) ();
    logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] i_samples;
    logic [NUM_CHANNELS-1:0]              i_mute;
    logic [NUM_CHANNELS*ATTEN_WIDTH-1:0]  i_atten;
    logic                                 i_sample_stb;
    logic                                 o_busy;
    logic [PWM_WIDTH-1:0]                 o_mix;
    logic                                 o_mix_valid;
    logic                                 o_clip;
    logic                                 o_pwm;
    logic                                 o_pwm_n;
    logic                                 o_cycle_end;

    modport master (
        output i_samples, i_mute, i_atten, i_sample_stb,
        input  o_busy, o_mix, o_mix_valid, o_clip, o_pwm, o_pwm_n, o_cycle_end
    );

    modport slave (
        input  i_samples, i_mute, i_atten, i_sample_stb,
        output o_busy, o_mix, o_mix_valid, o_clip, o_pwm, o_pwm_n, o_cycle_end
    );
endinterface

// File: rtl/channel_mixer_pwm.sv
// N-channel audio mixer feeding a free-running PWM output stage.
// A sample strobe snapshots all channels; the mix is accumulated one
// channel per clock, saturated to PWM_WIDTH bits and handed to the PWM,
// which only adopts a new compare value at period wrap.
// Optional feature: define CHANNEL_MIXER_AVERAGE_EN to divide the sum by
// 2^$clog2(NUM_CHANNELS) before saturation (default: plain saturating sum).
module channel_mixer_pwm #(
    parameter int NUM_CHANNELS = 4,
    parameter int SAMPLE_WIDTH = 9,
    parameter int ATTEN_WIDTH  = 2,
    parameter int PWM_WIDTH    = 10
) (
    input logic                 i_clk,
    input logic                 i_rst_n,
    channel_mixer_pwm_if.slave  bus
);

    localparam int ACC_W     = SAMPLE_WIDTH + $clog2(NUM_CHANNELS) + 1;
    localparam int IDX_W     = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int AVG_SHIFT = $clog2(NUM_CHANNELS);
    // Comparison width wide enough to hold both the sum and the PWM maximum.
    localparam int CMP_W     = (ACC_W > PWM_WIDTH) ? ACC_W : PWM_WIDTH + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHANNELS - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t state_q, state_d;

    logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] snap_samples;
    logic [NUM_CHANNELS-1:0]              snap_mute;
    logic [NUM_CHANNELS*ATTEN_WIDTH-1:0]  snap_atten;

    logic [IDX_W-1:0]        idx_q;
    logic [ACC_W-1:0]        acc_q;
    logic [PWM_WIDTH-1:0]    mix_q;
    logic                    mix_valid_q;
    logic                    clip_q;
    logic [PWM_WIDTH-1:0]    pending_cmp_q;
    logic [PWM_WIDTH-1:0]    active_cmp_q;
    logic [PWM_WIDTH-1:0]    pwm_cnt_q;

    logic                    start;
    logic                    done;
    logic                    last;
    logic [SAMPLE_WIDTH-1:0] cur_sample;
    logic [ATTEN_WIDTH-1:0]  cur_atten;
    logic [SAMPLE_WIDTH-1:0] term;
    logic [ACC_W-1:0]        scaled;
    logic                    sat;
    logic [PWM_WIDTH-1:0]    result;
    logic                    cycle_end;

    // Next-state and control decode for the mix sequencer.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d = state_q;
        start   = 1'b0;
        done    = 1'b0;
        last    = (idx_q == LAST_IDX);
        case (state_q)
            IDLE: begin
                if (bus.i_sample_stb) begin
                    start   = 1'b1;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (last) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Sequencer state register; reset aborts any mix in progress.
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // flop samples pre-edge values regardless of statement order.
        if (!i_rst_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Snapshot of channel inputs taken when a mix starts.
    always_ff @(posedge i_clk) begin
        // NOTE: pure data registers, always loaded before being read, so they
        // carry no reset.
        if (start) begin
            snap_samples <= bus.i_samples;
            snap_mute    <= bus.i_mute;
            snap_atten   <= bus.i_atten;
        end
    end

    // Current channel contribution after mute and shift attenuation.
    always_comb begin
        cur_sample = snap_samples[idx_q*SAMPLE_WIDTH +: SAMPLE_WIDTH];
        cur_atten  = snap_atten[idx_q*ATTEN_WIDTH +: ATTEN_WIDTH];
        term       = snap_mute[idx_q] ? '0 : (cur_sample >> cur_atten);
    end

    // Final scaling and saturation of the accumulated sum.
    always_comb begin
`ifdef CHANNEL_MIXER_AVERAGE_EN
        scaled = acc_q >> AVG_SHIFT;
`else
        scaled = acc_q;
`endif
        sat    = CMP_W'(scaled) > CMP_W'({PWM_WIDTH{1'b1}});
        result = sat ? {PWM_WIDTH{1'b1}} : PWM_WIDTH'(scaled);
    end

    // Accumulator, channel index and registered mix result.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            idx_q         <= '0;
            acc_q         <= '0;
            mix_q         <= '0;
            mix_valid_q   <= 1'b0;
            clip_q        <= 1'b0;
            pending_cmp_q <= '0;
        end else begin
            mix_valid_q <= 1'b0;
            clip_q      <= 1'b0;
            if (start) begin
                idx_q <= '0;
                acc_q <= '0;
            end else if (state_q == ACCUM) begin
                acc_q <= acc_q + ACC_W'(term);
                idx_q <= last ? '0 : idx_q + 1'b1;
            end
            if (done) begin
                mix_q         <= result;
                mix_valid_q   <= 1'b1;
                clip_q        <= sat;
                pending_cmp_q <= result;
            end
        end
    end

    // Free-running PWM counter; compare is swapped only at period wrap.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            pwm_cnt_q    <= '0;
            active_cmp_q <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + 1'b1;
            if (cycle_end) active_cmp_q <= pending_cmp_q;
        end
    end

    assign cycle_end       = (pwm_cnt_q == {PWM_WIDTH{1'b1}});
    assign bus.o_busy      = (state_q != IDLE);
    assign bus.o_mix       = mix_q;
    assign bus.o_mix_valid = mix_valid_q;
    assign bus.o_clip      = clip_q;
    assign bus.o_pwm       = (pwm_cnt_q < active_cmp_q);
    assign bus.o_pwm_n     = ~(pwm_cnt_q < active_cmp_q);
    assign bus.o_cycle_end = cycle_end;

endmodule

// File: tb/tb_channel_mixer_pwm.sv
// Scoreboard bench for channel_mixer_pwm: stimulus pushes hand-computed
// mix results into a queue, a monitor pops and compares on o_mix_valid.
module tb_channel_mixer_pwm;

    localparam int N  = 4;
    localparam int SW = 9;
    localparam int AW = 2;
    localparam int PW = 10;

    typedef struct {
        int mix;
        int clip;
    } exp_t;

    logic i_clk;
    logic i_rst_n;

    int total = 0;
    int bad   = 0;
    exp_t exp_q[$];

    channel_mixer_pwm_if #(.NUM_CHANNELS(N), .SAMPLE_WIDTH(SW),
                           .ATTEN_WIDTH(AW), .PWM_WIDTH(PW)) bus ();

    channel_mixer_pwm #(.NUM_CHANNELS(N), .SAMPLE_WIDTH(SW),
                        .ATTEN_WIDTH(AW), .PWM_WIDTH(PW)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Hand-computed expectations for both build flavours.
`ifdef CHANNEL_MIXER_AVERAGE_EN
    localparam int E_BASIC = 25,  C_BASIC = 0;
    localparam int E_MUTE  = 12,  C_MUTE  = 0;
    localparam int E_ATT   = 100, C_ATT   = 0;
    localparam int E_EDGE  = 255, C_EDGE  = 0;
    localparam int E_OVER  = 256, C_OVER  = 0;
    localparam int E_FULL  = 511, C_FULL  = 0;
    localparam int E_BUSY  = 2,   C_BUSY  = 0;
    localparam int E_POST  = 4,   C_POST  = 0;
`else
    localparam int E_BASIC = 100,  C_BASIC = 0;
    localparam int E_MUTE  = 50,   C_MUTE  = 0;
    localparam int E_ATT   = 400,  C_ATT   = 0;
    localparam int E_EDGE  = 1023, C_EDGE  = 0;
    localparam int E_OVER  = 1023, C_OVER  = 1;
    localparam int E_FULL  = 1023, C_FULL  = 1;
    localparam int E_BUSY  = 10,   C_BUSY  = 0;
    localparam int E_POST  = 18,   C_POST  = 0;
`endif

    task automatic check(input string name, input int actual, input int expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic logic [N*SW-1:0] pack4(input int s0, input int s1, input int s2, input int s3);
        return {SW'(s3), SW'(s2), SW'(s1), SW'(s0)};
    endfunction

    // Monitor: every result pulse must match the oldest expectation.
    always @(negedge i_clk) begin
        if (bus.o_mix_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid: got mix=%0d with no pending expectation (t=%0t)",
                         bus.o_mix, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_mix", int'(bus.o_mix), e.mix);
                check("sb_clip", int'(bus.o_clip), e.clip);
            end
        end
    end

    // Issue one strobe and measure latency and busy behaviour.
    task automatic run_mix(input string tag, input logic [N*SW-1:0] s, input logic [N-1:0] m,
                           input logic [N*AW-1:0] a, input int exp_mix, input int exp_clip);
        exp_t e;
        int cyc;
        e.mix  = exp_mix;
        e.clip = exp_clip;
        exp_q.push_back(e);
        @(posedge i_clk); #1;
        bus.i_samples    = s;
        bus.i_mute       = m;
        bus.i_atten      = a;
        bus.i_sample_stb = 1'b1;
        @(posedge i_clk); #1;
        bus.i_sample_stb = 1'b0;
        cyc = 1;
        check({tag, "_busy1"}, int'(bus.o_busy), 1);
        while (!bus.o_mix_valid && cyc < 20) begin
            @(posedge i_clk); #1;
            cyc++;
        end
        check({tag, "_latency"}, cyc, N + 2);
        check({tag, "_busy_end"}, int'(bus.o_busy), 0);
    endtask

    initial begin
        int cyc;
        int highs;
        int inv_err;
        int seen;
        exp_t e;

        i_rst_n          = 1'b0;
        bus.i_samples    = '0;
        bus.i_mute       = '0;
        bus.i_atten      = '0;
        bus.i_sample_stb = 1'b0;

        // Reset held for three cycles.
        repeat (3) @(posedge i_clk);
        #1;
        check("rst_pwm", int'(bus.o_pwm), 0);
        check("rst_pwm_n", int'(bus.o_pwm_n), 1);
        check("rst_mix", int'(bus.o_mix), 0);
        check("rst_busy", int'(bus.o_busy), 0);
        check("rst_cycle_end", int'(bus.o_cycle_end), 0);
        i_rst_n = 1'b1;
        repeat (5) @(posedge i_clk);
        #1;
        check("idle_busy", int'(bus.o_busy), 0);

        // Basic sum, then PWM duty over one full period.
        run_mix("basic", pack4(10, 20, 30, 40), 4'b0000, 8'h00, E_BASIC, C_BASIC);
        seen = 0;
        cyc  = 0;
        while (!seen && cyc < 1100) begin
            if (bus.o_cycle_end) seen = 1;
            else begin
                @(posedge i_clk); #1;
                cyc++;
            end
        end
        check("cycle_end_seen", seen, 1);
        highs   = 0;
        inv_err = 0;
        for (int i = 0; i < (1 << PW); i++) begin
            @(posedge i_clk); #1;
            if (bus.o_pwm) highs++;
            if (bus.o_pwm_n !== ~bus.o_pwm) inv_err++;
        end
        check("pwm_high_count", highs, E_BASIC);
        check("pwm_n_inverse_errors", inv_err, 0);

        // Mute channel 1, attenuate channel 3 by 2.
        run_mix("mute", pack4(10, 20, 30, 40), 4'b0010, 8'h80, E_MUTE, C_MUTE);
        // Distinct shift on every channel: 200 + 75 + 25 + 100.
        run_mix("atten", pack4(400, 300, 200, 100), 4'b0000, 8'h39, E_ATT, C_ATT);
        // Exactly full scale, no clip.
        run_mix("edge", pack4(511, 511, 1, 0), 4'b0000, 8'h00, E_EDGE, C_EDGE);
        // One above full scale.
        run_mix("over", pack4(511, 511, 2, 0), 4'b0000, 8'h00, E_OVER, C_OVER);
        // All channels at maximum.
        run_mix("full", pack4(511, 511, 511, 511), 4'b0000, 8'h00, E_FULL, C_FULL);

        // Busy handling: inputs change in cycle 1, second strobe in cycle 3.
        e.mix  = E_BUSY;
        e.clip = C_BUSY;
        exp_q.push_back(e);
        @(posedge i_clk); #1;
        bus.i_samples    = pack4(1, 2, 3, 4);
        bus.i_mute       = '0;
        bus.i_atten      = '0;
        bus.i_sample_stb = 1'b1;
        @(posedge i_clk); #1;
        bus.i_sample_stb = 1'b0;
        bus.i_samples    = pack4(100, 100, 100, 100);
        cyc = 1;
        @(posedge i_clk); #1;
        cyc++;
        bus.i_sample_stb = 1'b1;
        @(posedge i_clk); #1;
        cyc++;
        bus.i_sample_stb = 1'b0;
        while (!bus.o_mix_valid && cyc < 20) begin
            @(posedge i_clk); #1;
            cyc++;
        end
        check("busy_latency", cyc, N + 2);
        repeat (12) @(posedge i_clk);
        #1;
        check("busy_pending", exp_q.size(), 0);

        // Reset asserted in cycle 2 of a mix.
        bus.i_samples    = pack4(50, 60, 70, 80);
        bus.i_sample_stb = 1'b1;
        @(posedge i_clk); #1;
        bus.i_sample_stb = 1'b0;
        check("abort_busy_before", int'(bus.o_busy), 1);
        @(posedge i_clk); #1;
        i_rst_n = 1'b0;
        @(posedge i_clk); #1;
        check("abort_busy", int'(bus.o_busy), 0);
        check("abort_mix", int'(bus.o_mix), 0);
        i_rst_n = 1'b1;
        repeat (12) @(posedge i_clk);
        #1;
        check("abort_mix_later", int'(bus.o_mix), 0);

        // Strobe coincident with reset: reset wins.
        i_rst_n          = 1'b0;
        bus.i_sample_stb = 1'b1;
        @(posedge i_clk); #1;
        bus.i_sample_stb = 1'b0;
        i_rst_n          = 1'b1;
        check("stb_rst_busy", int'(bus.o_busy), 0);
        repeat (10) @(posedge i_clk);
        #1;

        // Recovery after reset: channel 3 muted.
        run_mix("post", pack4(5, 6, 7, 8), 4'b1000, 8'h00, E_POST, C_POST);

        repeat (4) @(posedge i_clk);
        #1;
        check("sb_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
